latency_meas_sched: RTL and testbench

- Shares the single global latency counter between NUM_REQ requesters that each want one start-to-stop interval measured.
- Grants requesters round-robin and drives the counter's start and stop controls.
- Captures the final count and returns it to the winner over a valid/ready result port.
- Sits between the per-channel handshake monitors and the global counter instance.

---
 rtl/latency_meas_sched.sv | 208 ++++++++++++++++++++
 tb/tb_latency_meas_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_meas_sched.sv
// latency_meas_sched
// Shares one global latency counter between NUM_REQ requesters. A round-robin
// arbiter grants one requester at a time; the FSM drives the counter's start
// and stop controls from that requester's events, captures the final count,
// and returns it over a valid/ready result port. Every output is a register.

module latency_meas_sched #(
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_VAL = 31
) (
    input  logic               clk,
    input  logic               GlobalReset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] start_evt,
    input  logic [NUM_REQ-1:0] stop_evt,
    output logic [NUM_REQ-1:0] grant,
    output logic               ctr_start,
    output logic               ctr_stop,
    input  logic [CNT_W-1:0]   ctr_count,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_id,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_VAL);
    localparam logic [2:0]       RR_RESET    = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_STOPPING,
        S_CAPTURE,
        S_RESULT
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [2:0]           gidx_q, gidx_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic                 ctr_start_q, ctr_start_d;
    logic                 ctr_stop_q, ctr_stop_d;
    logic                 tmo_flag_q, tmo_flag_d;
    logic                 res_valid_q, res_valid_d;
    logic [2:0]           res_id_q, res_id_d;
    logic [CNT_W-1:0]     res_count_q, res_count_d;
    logic                 res_timeout_q, res_timeout_d;

    // Arbiter results
    logic                 any_req;
    logic                 hi_found;
    logic [2:0]           hi_idx;
    logic [2:0]           lo_idx;
    logic [2:0]           pick_idx;

    // Events of the granted requester only; the others are masked off here
    logic                 req_hit;
    logic                 start_hit;
    logic                 stop_hit;

    assign req_hit   = |(req & grant_q);
    assign start_hit = |(start_evt & grant_q);
    assign stop_hit  = |(stop_evt & grant_q);

    // Round-robin pick: lowest set req above rr_ptr, else lowest set req overall
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        any_req  = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan so the lowest matching index is the last one written
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                lo_idx  = 3'(i);
                if (3'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    // Next-state and registered-output logic of the measurement FSM
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        ctr_start_d   = 1'b0;
        ctr_stop_d    = 1'b0;
        tmo_flag_d    = tmo_flag_q;
        res_valid_d   = res_valid_q;
        res_id_d      = res_id_q;
        res_count_d   = res_count_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                // A withdrawn request releases the counter without a result;
                // stop events are meaningless before the measurement starts
                if (!req_hit) begin
                    grant_d  = '0;
                    rr_ptr_d = gidx_q;
                    state_d  = S_IDLE;
                end else if (start_hit) begin
                    ctr_start_d = 1'b1;
                    state_d     = S_RUN;
                end
            end

            S_RUN: begin
                // The stop event has priority over a coincident timeout. While
                // ctr_start is still high the counter shows its stale value
                // from the previous run, so the timeout is not judged then.
                if (stop_hit) begin
                    ctr_stop_d = 1'b1;
                    tmo_flag_d = 1'b0;
                    state_d    = S_STOPPING;
                end else if (!ctr_start_q && (ctr_count >= TIMEOUT_CNT)) begin
                    ctr_stop_d = 1'b1;
                    tmo_flag_d = 1'b1;
                    state_d    = S_STOPPING;
                end
            end

            S_STOPPING: begin
                // The counter takes its final increment on this cycle's edge
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                res_count_d   = ctr_count;
                res_id_d      = gidx_q;
                res_timeout_d = tmo_flag_q;
                res_valid_d   = 1'b1;
                state_d       = S_RESULT;
            end

            S_RESULT: begin
                // Grant is held until the result is taken, even if req drops
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    grant_d     = '0;
                    rr_ptr_d    = gidx_q;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by GlobalReset_n
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= RR_RESET;
            ctr_start_q   <= 1'b0;
            ctr_stop_q    <= 1'b0;
            tmo_flag_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            rr_ptr_q      <= rr_ptr_d;
            ctr_start_q   <= ctr_start_d;
            ctr_stop_q    <= ctr_stop_d;
            tmo_flag_q    <= tmo_flag_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_count_q   <= res_count_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign grant       = grant_q;
    assign ctr_start   = ctr_start_q;
    assign ctr_stop    = ctr_stop_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_count   = res_count_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_latency_meas_sched.sv
// tb_latency_meas_sched
// Directed bench for latency_meas_sched with a behavioural model of the
// global counter attached: ctr_start clears and starts it, it increments every
// cycle while running, and it takes one final increment on the edge where
// ctr_stop is high before halting.

module tb_latency_meas_sched;

    localparam int NUM_REQ     = 4;
    localparam int CNT_W       = 5;
    localparam int TIMEOUT_VAL = 31;

    logic               clk = 1'b0;
    logic               GlobalReset_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] start_evt;
    logic [NUM_REQ-1:0] stop_evt;
    logic [NUM_REQ-1:0] grant;
    logic               ctr_start;
    logic               ctr_stop;
    logic [CNT_W-1:0]   ctr_count;
    logic               res_valid;
    logic               res_ready;
    logic [2:0]         res_id;
    logic [CNT_W-1:0]   res_count;
    logic               res_timeout;

    int n_vec = 0;
    int n_err = 0;
    int n_start_pulses = 0;
    int n_stop_pulses  = 0;

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_run_q;

    latency_meas_sched #(
        .NUM_REQ    (NUM_REQ),
        .CNT_W      (CNT_W),
        .TIMEOUT_VAL(TIMEOUT_VAL)
    ) dut (
        .clk          (clk),
        .GlobalReset_n(GlobalReset_n),
        .req          (req),
        .start_evt    (start_evt),
        .stop_evt     (stop_evt),
        .grant        (grant),
        .ctr_start    (ctr_start),
        .ctr_stop     (ctr_stop),
        .ctr_count    (ctr_count),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_count    (res_count),
        .res_timeout  (res_timeout)
    );

    always #5 clk = ~clk;

    // Global counter model
    assign ctr_count = cnt_q;
    always @(posedge clk) begin
        if (!GlobalReset_n) begin
            cnt_q     <= '0;
            cnt_run_q <= 1'b0;
        end else if (ctr_start) begin
            cnt_q     <= '0;
            cnt_run_q <= 1'b1;
        end else if (cnt_run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (ctr_stop) cnt_run_q <= 1'b0;
        end
    end

    // Count the clock cycles in which each counter control was high
    always @(posedge clk) begin
        if (GlobalReset_n) begin
            if (ctr_start) n_start_pulses <= n_start_pulses + 1;
            if (ctr_stop)  n_stop_pulses  <= n_stop_pulses + 1;
        end
    end

    // Inputs are driven and outputs sampled 1 ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        GlobalReset_n = 1'b0;
        req           = '0;
        start_evt     = '0;
        stop_evt      = '0;
        res_ready     = 1'b0;
        tick();
        tick();
        GlobalReset_n = 1'b1;
    endtask

    task automatic test_reset();
        GlobalReset_n = 1'b0;
        req           = '0;
        start_evt     = '0;
        stop_evt      = '0;
        res_ready     = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({grant, ctr_start, ctr_stop, res_valid, res_id, res_count, res_timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: grant=%b start=%b stop=%b valid=%b id=%0d count=%0d tmo=%b, required all zero",
                     grant, ctr_start, ctr_stop, res_valid, res_id, res_count, res_timeout);
        end
        GlobalReset_n = 1'b1;
        req = 4'b0100;
        n_vec++;
        if (grant !== 4'b0000) begin
            n_err++;
            $display("FAIL grant_before_edge: got %b required 0000", grant);
        end
        tick();
        n_vec++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL first_grant: got %b required 0100", grant);
        end
        tick();
        n_vec++;
        if (grant !== 4'b0100 || ctr_start !== 1'b0) begin
            n_err++;
            $display("FAIL armed_hold: grant=%b start=%b required 0100 / 0", grant, ctr_start);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_measure();
        int base_start;
        int base_stop;
        apply_reset();
        base_start = n_start_pulses;
        base_stop  = n_stop_pulses;
        req = 4'b0001;
        tick();                                   // P1: ARMED
        n_vec++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL meas_grant: got %b required 0001", grant);
        end
        stop_evt = 4'b0001;                       // stop alone in ARMED
        tick();                                   // P2
        start_evt = 4'b0001;                      // start + stop together
        stop_evt  = 4'b0001;
        tick();                                   // P3
        start_evt = '0;
        stop_evt  = '0;
        n_vec++;
        if (ctr_start !== 1'b1 || ctr_stop !== 1'b0) begin
            n_err++;
            $display("FAIL meas_start_pulse: start=%b stop=%b required 1 / 0", ctr_start, ctr_stop);
        end
        tick();                                   // P4
        n_vec++;
        if (ctr_start !== 1'b0) begin
            n_err++;
            $display("FAIL meas_start_width: got %b required 0", ctr_start);
        end
        tick();                                   // P5
        start_evt = 4'b0001;                      // second start during RUN
        tick();
        start_evt = '0;
        tick();
        tick();
        tick();                                   // P9: T+7
        stop_evt = 4'b0001;
        tick();                                   // P10
        stop_evt = '0;
        n_vec++;
        if (ctr_stop !== 1'b1) begin
            n_err++;
            $display("FAIL meas_stop_pulse: got %b required 1", ctr_stop);
        end
        tick();                                   // P11
        n_vec++;
        if (ctr_stop !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL meas_capture: stop=%b valid=%b required 0 / 0", ctr_stop, res_valid);
        end
        tick();                                   // P12
        n_vec++;
        if (res_valid !== 1'b1 || res_id !== 3'd0 || res_count !== 5'd7 || res_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL meas_result: valid=%b id=%0d count=%0d tmo=%b required 1 / 0 / 7 / 0",
                     res_valid, res_id, res_count, res_timeout);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (res_valid !== 1'b1 || res_id !== 3'd0 || res_count !== 5'd7 ||
                res_timeout !== 1'b0 || grant !== 4'b0001) begin
                n_err++;
                $display("FAIL meas_hold[%0d]: valid=%b id=%0d count=%0d tmo=%b grant=%b required 1/0/7/0/0001",
                         k, res_valid, res_id, res_count, res_timeout, grant);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        req       = '0;
        n_vec++;
        if (res_valid !== 1'b0 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL meas_handshake: valid=%b grant=%b required 0 / 0000", res_valid, grant);
        end
        n_vec++;
        if (n_start_pulses - base_start !== 1 || n_stop_pulses - base_stop !== 1) begin
            n_err++;
            $display("FAIL meas_pulse_count: start=%0d stop=%0d required 1 / 1",
                     n_start_pulses - base_start, n_stop_pulses - base_stop);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int g;
        int w;
        apply_reset();
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            g = order[n];
            w = 0;
            tick();
            while (grant === 4'b0000 && w < 8) begin
                tick();
                w++;
            end
            n_vec++;
            if (grant !== 4'(1 << g)) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b required %b", n, grant, 4'(1 << g));
            end
            start_evt = 4'(1 << g);
            tick();
            start_evt = '0;
            tick();
            tick();
            stop_evt = 4'(1 << g);
            tick();
            stop_evt = '0;
            w = 0;
            while (res_valid !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            n_vec++;
            if (res_valid !== 1'b1 || res_id !== 3'(g) || res_count !== 5'd3 || res_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL rr_result[%0d]: valid=%b id=%0d count=%0d tmo=%b required 1 / %0d / 3 / 0",
                         n, res_valid, res_id, res_count, res_timeout, g);
            end
        end
        tick();
        req       = '0;
        res_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [CNT_W-1:0] prev;
        int w;
        apply_reset();
        req = 4'b0100;
        tick();
        n_vec++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL tmo_grant: got %b required 0100", grant);
        end
        start_evt = 4'b0100;
        tick();
        start_evt = '0;
        n_vec++;
        if (ctr_start !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_start: got %b required 1", ctr_start);
        end
        prev = ctr_count;
        w    = 0;
        while (ctr_stop !== 1'b1 && w < 60) begin
            prev = ctr_count;
            tick();
            w++;
        end
        n_vec++;
        if (ctr_stop !== 1'b1 || prev !== 5'd31 || w != 33) begin
            n_err++;
            $display("FAIL tmo_stop: stop=%b count_before=%0d cycles=%0d required 1 / 31 / 33",
                     ctr_stop, prev, w);
        end
        w = 0;
        while (res_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        n_vec++;
        if (res_valid !== 1'b1 || res_id !== 3'd2 || res_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_result: valid=%b id=%0d tmo=%b required 1 / 2 / 1", res_valid, res_id, res_timeout);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        req       = '0;
        n_vec++;
        if (res_valid !== 1'b0 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL tmo_handshake: valid=%b grant=%b required 0 / 0000", res_valid, grant);
        end
        tick();
    endtask

    task automatic test_abort();
        int base_start;
        apply_reset();
        base_start = n_start_pulses;
        req = 4'b0010;
        tick();
        n_vec++;
        if (grant !== 4'b0010) begin
            n_err++;
            $display("FAIL abort_grant: got %b required 0010", grant);
        end
        start_evt = 4'b1000;
        stop_evt  = 4'b1000;
        tick();
        start_evt = '0;
        stop_evt  = '0;
        n_vec++;
        if (ctr_start !== 1'b0 || grant !== 4'b0010) begin
            n_err++;
            $display("FAIL abort_foreign_evt: start=%b grant=%b required 0 / 0010", ctr_start, grant);
        end
        req = '0;
        tick();
        n_vec++;
        if (grant !== 4'b0000 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: grant=%b valid=%b required 0000 / 0", grant, res_valid);
        end
        req = 4'b1111;
        tick();
        n_vec++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL abort_next_rr: got %b required 0100", grant);
        end
        n_vec++;
        if (n_start_pulses - base_start !== 0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_result: start_pulses=%0d valid=%b required 0 / 0",
                     n_start_pulses - base_start, res_valid);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req = 4'b0001;
        tick();
        start_evt = 4'b0001;
        tick();
        start_evt = '0;
        n_vec++;
        if (ctr_start !== 1'b1 || grant !== 4'b0001) begin
            n_err++;
            $display("FAIL midrst_setup: start=%b grant=%b required 1 / 0001", ctr_start, grant);
        end
        #2;
        GlobalReset_n = 1'b0;
        #1;
        n_vec++;
        if (grant !== 4'b0000 || res_valid !== 1'b0 || ctr_start !== 1'b0 || ctr_stop !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: grant=%b valid=%b start=%b stop=%b required all 0",
                     grant, res_valid, ctr_start, ctr_stop);
        end
        tick();
        GlobalReset_n = 1'b1;
        tick();
        n_vec++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL midrst_regrant: got %b required 0001", grant);
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_measure();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
